// File: rtl/funct_encoder_if.sv
// Request/response bundle for the R-type funct encoder.
// The master drives requests and consumes words; the slave is the encoder.
interface funct_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_op;
  logic          is_unsigned;
  logic          is_jr;
  logic          is_syscall;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          err;
  logic [7:0]    err_cnt;
  logic [LW-1:0] level;

  modport master (
    output in_valid, alu_op, is_unsigned,
    output is_jr, is_syscall,
    output rs, rt, rd, shamt,
    output flush, out_ready,
    input  in_ready, out_valid, out_instr,
    input  err, err_cnt, level
  );

  modport slave (
    input  in_valid, alu_op, is_unsigned,
    input  is_jr, is_syscall,
    input  rs, rt, rd, shamt,
    input  flush, out_ready,
    output in_ready, out_valid, out_instr,
    output err, err_cnt, level
  );
endinterface

// File: rtl/funct_encoder.sv
// Turns ALU control codes back into MIPS R-type words
// and queues them in a small FIFO for the consumer.
module funct_encoder #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  funct_encoder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] lvl;
  logic          err_q;
  logic [7:0]    cnt;

  logic [5:0]  funct;
  logic        shift;
  logic        illegal;
  logic        bad;
  logic [31:0] word;
  logic        full;
  logic        acc;
  logic        push;
  logic        pop;

  always_comb begin
    funct   = 6'h00;
    shift   = 1'b0;
    illegal = 1'b0;
    unique case (bus.alu_op)
      4'b0000: begin funct = 6'h00; shift = 1'b1; end
      4'b0100: begin funct = 6'h02; shift = 1'b1; end
      4'b1000: begin funct = 6'h03; shift = 1'b1; end
      4'b1010: funct = bus.is_unsigned ? 6'h21 : 6'h20;
      4'b0110: funct = 6'h22;
      4'b1110: funct = 6'h24;
      4'b0001: funct = 6'h25;
      4'b0101: funct = 6'h27;
      4'b1101: funct = 6'h2A;
      4'b0011: funct = 6'h2B;
      default: illegal = 1'b1;
    endcase
  end

  // syscall outranks jr, which outranks the alu code
  always_comb begin
    word = 32'h0;
    if (bus.is_syscall)
      word = 32'h0000000C;
    else if (bus.is_jr)
      word = {6'b0, bus.rs, 15'b0, 6'h08};
    else if (shift)
      word = {11'b0, bus.rt, bus.rd,
              bus.shamt, funct};
    else
      word = {6'b0, bus.rs, bus.rt, bus.rd,
              5'b0, funct};
  end

  assign bad  = illegal && !bus.is_jr
                && !bus.is_syscall;
  assign full = (lvl == LW'(DEPTH));
  assign acc  = bus.in_valid && !full;
  assign push = acc && !bad && !bus.flush;
  assign pop  = (lvl != '0) && bus.out_ready
                && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else if (bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        lvl <= lvl + 1'b1;
      else if (pop && !push)
        lvl <= lvl - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt   <= 8'h00;
    end else begin
      err_q <= acc && bad;
      if (acc && bad && cnt != 8'hFF)
        cnt <= cnt + 8'h01;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = (lvl != '0);
  assign bus.out_instr = mem[rp];
  assign bus.err       = err_q;
  assign bus.err_cnt   = cnt;
  assign bus.level     = lvl;
endmodule

// File: tb/tb_funct_encoder.sv
// Directed bench for funct_encoder with a word scoreboard.
// Expected words are pushed on acceptance and popped on each pop.
module tb_funct_encoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   npulse;
  logic [31:0] sbq [$];
  logic [32:0] m;

  funct_encoder_if #(.DEPTH(DEPTH)) bus ();

  funct_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  // reference encoder: {legal, word}
  function automatic logic [32:0] model(
    input logic sys, input logic jr,
    input logic [3:0] op, input logic u,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh);
    logic [5:0] f;
    logic sft;
    sft = 1'b0;
    f = 6'h00;
    if (sys) return {1'b1, 32'h0000000C};
    if (jr) return {1'b1, 6'b0, rs, 15'b0, 6'h08};
    case (op)
      4'h0: begin f = 6'h00; sft = 1'b1; end
      4'h4: begin f = 6'h02; sft = 1'b1; end
      4'h8: begin f = 6'h03; sft = 1'b1; end
      4'hA: f = u ? 6'h21 : 6'h20;
      4'h6: f = 6'h22;
      4'hE: f = 6'h24;
      4'h1: f = 6'h25;
      4'h5: f = 6'h27;
      4'hD: f = 6'h2A;
      4'h3: f = 6'h2B;
      default: return {1'b0, 32'h0};
    endcase
    if (sft)
      return {1'b1, 11'b0, rt, rd, sh, f};
    return {1'b1, 6'b0, rs, rt, rd, 5'b0, f};
  endfunction

  // inputs only change at posedge+1, so negedge
  // values are the ones the next edge acts on
  always @(negedge clk) begin
    if (!rst_n || bus.flush) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        total++;
        assert (sbq.size() != 0) else begin
          bad++;
          $error("FAIL sb_extra got=%h exp=none",
                 bus.out_instr);
        end
        if (sbq.size() != 0)
          chk("sb_word", bus.out_instr,
              sbq.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        m = model(bus.is_syscall, bus.is_jr,
                  bus.alu_op, bus.is_unsigned,
                  bus.rs, bus.rt, bus.rd,
                  bus.shamt);
        if (m[32]) sbq.push_back(m[31:0]);
      end
    end
  end

  task automatic req(input logic [3:0] op,
                     input logic u,
                     input logic jr,
                     input logic sys,
                     input logic [4:0] rs,
                     input logic [4:0] rt,
                     input logic [4:0] rd,
                     input logic [4:0] sh);
    bus.in_valid    = 1'b1;
    bus.alu_op      = op;
    bus.is_unsigned = u;
    bus.is_jr       = jr;
    bus.is_syscall  = sys;
    bus.rs          = rs;
    bus.rt          = rt;
    bus.rd          = rd;
    bus.shamt       = sh;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.level == '0) break;
      tick();
    end
    chk(tag, 32'(bus.level), 32'd0);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.alu_op      = 4'h0;
    bus.is_unsigned = 1'b0;
    bus.is_jr       = 1'b0;
    bus.is_syscall  = 1'b0;
    bus.rs          = 5'd0;
    bus.rt          = 5'd0;
    bus.rd          = 5'd0;
    bus.shamt       = 5'd0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    #1;
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_iready", 32'(bus.in_ready), 32'd1);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_errcnt", 32'(bus.err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD rd=3, rs=1, rt=2
    req(4'hA, 1'b0, 1'b0, 1'b0,
        5'd1, 5'd2, 5'd3, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("add_word", bus.out_instr, 32'h00221820);
    chk("add_level", 32'(bus.level), 32'd1);
    drain("add_drain");

    // SRA ignores rs
    bus.out_ready = 1'b0;
    req(4'h8, 1'b0, 1'b0, 1'b0,
        5'd31, 5'd5, 5'd6, 5'd4);
    tick();
    bus.in_valid = 1'b0;
    chk("sra_word", bus.out_instr, 32'h00053103);
    drain("sra_drain");

    // syscall beats jr and an illegal code
    bus.out_ready = 1'b0;
    req(4'h2, 1'b0, 1'b1, 1'b1,
        5'd9, 5'd9, 5'd9, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    chk("sys_word", bus.out_instr, 32'h0000000C);
    chk("sys_err", 32'(bus.err), 32'd0);
    drain("sys_drain");

    bus.out_ready = 1'b0;
    req(4'hF, 1'b0, 1'b1, 1'b0,
        5'd7, 5'd1, 5'd1, 5'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("jr_word", bus.out_instr, 32'h00E00008);
    drain("jr_drain");

    // every legal code, streaming
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req(4'(i), 1'(i >> 1), 1'b0, 1'b0,
          5'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom));
      if (!model(1'b0, 1'b0, 4'(i), 1'b0,
                 5'd0, 5'd0, 5'd0, 5'd0)
          [32]) continue;
      tick();
    end
    drain("mix_drain");
    chk("mix_errcnt", 32'(bus.err_cnt), 32'd0);

    // fill to DEPTH, 5th request must stall
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(4'h1, 1'b0, 1'b0, 1'b0,
          5'(i), 5'(i + 8), 5'(i + 16), 5'd0);
      tick();
    end
    chk("full_iready", 32'(bus.in_ready), 32'd0);
    chk("full_level", 32'(bus.level), 32'd4);
    req(4'hE, 1'b0, 1'b0, 1'b0,
        5'd4, 5'd5, 5'd6, 5'd0);
    tick();
    chk("stall_level", 32'(bus.level), 32'd4);
    bus.out_ready = 1'b1;
    tick();
    chk("pop_level", 32'(bus.level), 32'd3);
    tick();
    bus.in_valid = 1'b0;
    chk("pushpop_level", 32'(bus.level), 32'd3);
    drain("full_drain");

    // illegal flood saturates the counter
    bus.out_ready = 1'b1;
    npulse = 0;
    req(4'hF, 1'b0, 1'b0, 1'b0,
        5'd1, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < 260; i++) begin
      tick();
      if (bus.err) npulse++;
    end
    bus.in_valid = 1'b0;
    chk("ill_pulses", npulse, 32'd260);
    chk("ill_cnt", 32'(bus.err_cnt), 32'd255);
    chk("ill_level", 32'(bus.level), 32'd0);
    tick();
    chk("ill_errlow", 32'(bus.err), 32'd0);

    // level 3, push+pop, then flush
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(4'h6, 1'b0, 1'b0, 1'b0,
          5'(i), 5'(i), 5'(i), 5'd0);
      tick();
    end
    chk("l3_level", 32'(bus.level), 32'd3);
    req(4'hD, 1'b0, 1'b0, 1'b0,
        5'd3, 5'd4, 5'd5, 5'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("pp_level", 32'(bus.level), 32'd3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_level", 32'(bus.level), 32'd0);
    chk("fl_ovalid", 32'(bus.out_valid), 32'd0);
    chk("fl_errcnt", 32'(bus.err_cnt), 32'd255);

    // asynchronous reset with words queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req(4'h5, 1'b0, 1'b0, 1'b0,
          5'(i), 5'd1, 5'd2, 5'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ovalid", 32'(bus.out_valid), 32'd0);
    chk("ar_level", 32'(bus.level), 32'd0);
    chk("ar_iready", 32'(bus.in_ready), 32'd1);
    chk("ar_errcnt", 32'(bus.err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_noemit", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    req(4'hA, 1'b1, 1'b0, 1'b0,
        5'd1, 5'd2, 5'd3, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("addu_word", bus.out_instr, 32'h00221821);
    drain("end_drain");
    chk("sb_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/funct_encoder.md
FUNCT_ENCODER -- requirements
Module: funct_encoder

Interface
REQ-001 SHALL declare parameter DEPTH, default 4, output FIFO entry count; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port alu_op  input  4  ALU control code to invert into a funct field.
REQ-007 SHALL have port is_unsigned  input  1  selects ADDU over ADD for alu_op 1010.
REQ-008 SHALL have port is_jr  input  1  request is JR.
REQ-009 SHALL have port is_syscall  input  1  request is SYSCALL.
REQ-010 SHALL have ports rs, rt, rd  input  5 each  register fields.
REQ-011 SHALL have port shamt  input  5  shift amount.
REQ-012 SHALL have port flush  input  1  synchronous clear of queued words.
REQ-013 SHALL have port out_valid  output  1  out_instr holds a queued word.
REQ-014 SHALL have port out_ready  input  1  consumer takes word when out_valid && out_ready.
REQ-015 SHALL have port out_instr  output  32  assembled R-type instruction word.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected request.
REQ-017 SHALL have port err_cnt  output  8  saturating count of rejected requests.
REQ-018 SHALL have port level  output  $clog2(DEPTH)+1  number of queued words.

Function
REQ-019 SHALL, on acceptance, select the encoding by priority is_syscall > is_jr > alu_op.
REQ-020 SHALL encode SYSCALL as 32'h0000000C, ignoring all field inputs.
REQ-021 SHALL encode JR as {6'b0, rs, 15'b0, 6'h08}.
REQ-022 SHALL map alu_op to funct as follows: 0000->SLL 0x00; 0100->SRL 0x02; 1000->SRA 0x03; 1010->ADD 0x20, or ADDU 0x21 if is_unsigned; 0110->SUB 0x22; 1110->AND 0x24; 0001->OR 0x25; 0101->NOR 0x27; 1101->SLT 0x2A; 0011->SLTU 0x2B.
REQ-023 SHALL encode shifts (SLL/SRL/SRA) as {6'b0, 5'b0, rt, rd, shamt, funct}.
REQ-024 SHALL encode all other ALU ops as {6'b0, rs, rt, rd, 5'b0, funct}.
REQ-025 SHALL treat alu_op codes 0010, 0111, 1001, 1011, 1100, 1111 (when neither is_jr nor is_syscall) as illegal: accept, do not enqueue, pulse err the next cycle, increment err_cnt saturating at 255.
REQ-026 SHALL drive in_ready = !full, where full means level == DEPTH; there is no pass-through when full.
REQ-027 SHALL drive out_valid = (level != 0) and out_instr = head entry, combinationally from registered state.
REQ-028 SHALL give one-cycle latency: a word accepted in cycle N is visible on out_instr in cycle N+1 when the FIFO was empty.
REQ-029 SHALL, on simultaneous push and pop, keep level unchanged and preserve order; this is legal whenever 0 < level < DEPTH.
REQ-030 SHALL wrap read and write pointers modulo DEPTH.
REQ-031 SHALL, on flush, set level=0 and both pointers=0 next cycle, dropping any same-cycle push or pop; err and err_cnt are unaffected.
REQ-032 SHALL hold out_instr stable while out_valid && !out_ready.
REQ-033 SHALL NOT count an illegal request arriving while full, since it is not accepted.

Reset
REQ-034 SHALL, on rst_n low, immediately clear level, pointers, err, and err_cnt, giving out_valid=0 and in_ready=1; FIFO storage contents are don't-care.
REQ-035 SHALL, on reset asserted mid-transfer, discard all queued words, with no partial word emitted after release.
REQ-036 SHALL resume accepting requests on the first rising edge after rst_n deasserts.

Verification
REQ-037 SHALL test: alu_op=1010, is_unsigned=0, rs=1, rt=2, rd=3 -> out_instr=32'h00221820 one cycle later, level=1.
REQ-038 SHALL test: alu_op=1000, rt=5, rd=6, shamt=4, rs=31 -> out_instr=32'h00053103 (rs field zero).
REQ-039 SHALL test: is_syscall=1 together with is_jr=1 and alu_op=0010 -> out_instr=32'h0000000C, err=0.
REQ-040 SHALL test: 5 pushes with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th push, 5th request stalls; then out_ready=1 drains the 4 words in order.
REQ-041 SHALL test: 260 illegal requests (alu_op=1111) -> err pulses each cycle, err_cnt=255, level=0.
REQ-042 SHALL test: level=3, then push+pop in the same cycle -> level=3; flush the next cycle -> level=0 and out_valid=0; rst_n low mid-stream -> out_valid=0 asynchronously.
